// File: rtl/riscv_structures.sv
// Shared RISC-V datapath types and constants used by the memory subsystem.
package riscv_structures;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  // Per-request control carried alongside the sampled word to the response port.
  typedef struct packed {
    logic       err;
    logic       we;
    logic [1:0] offset;
    logic [1:0] size;
    logic       is_unsigned;
  } rsp_ctl_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a memory word, shifts it to bit 0
// and sign- or zero-extends it to XLEN.
module load_align
  import riscv_structures::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  mem_size_t       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    result   = word;
    case (size)
      MEM_BYTE: result = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_HALF: result = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory: one request per cycle, fixed-latency in-order
// responses, byte-lane stores, aligned sub-word loads with extension.
module data_memory
  import riscv_structures::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            addr_oor;
  logic            misaligned;
  logic            req_err;
  logic [AW-1:0]   word_idx;
  logic [3:0]      lane_we;
  logic [XLEN-1:0] lane_wdata;

  logic [LATENCY-1:0] pipe_valid;
  rsp_ctl_t           pipe_ctl  [LATENCY];
  logic [XLEN-1:0]    pipe_word [LATENCY];
  rsp_ctl_t           out_ctl;
  logic [XLEN-1:0]    aligned;

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // ready only drops during reset, and responses are never back-pressured.
  assign req_ready = !rst;
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[2 +: AW];
  assign addr_oor  = |req_addr[XLEN-1:2+AW];

  always_comb begin
    misaligned = 1'b0;
    lane_we    = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size)
      MEM_BYTE: begin
        lane_we    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      MEM_HALF: begin
        misaligned = req_addr[0];
        lane_we    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      MEM_WORD: begin
        misaligned = |req_addr[1:0];
        lane_we    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign req_err = misaligned || addr_oor;

  // Array and data pipeline carry no reset so the array maps onto byte-enable block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept && req_we && !req_err && lane_we[i]) begin
        mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
    pipe_word[0] <= mem[word_idx];
    pipe_ctl[0]  <= '{err: req_err, we: req_we, offset: req_addr[1:0],
                      size: req_size, is_unsigned: req_unsigned};
    for (int s = 1; s < LATENCY; s++) begin
      pipe_word[s] <= pipe_word[s-1];
      pipe_ctl[s]  <= pipe_ctl[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
      end
    end
  end

  assign out_ctl = pipe_ctl[LATENCY-1];

  load_align u_load_align (
    .word        (pipe_word[LATENCY-1]),
    .offset      (out_ctl.offset),
    .size        (mem_size_t'(out_ctl.size)),
    .is_unsigned (out_ctl.is_unsigned),
    .result      (aligned)
  );

  assign rsp_valid = !rst && pipe_valid[LATENCY-1];
  assign rsp_err   = rsp_valid && out_ctl.err;
  assign rsp_rdata = (rsp_valid && !out_ctl.err && !out_ctl.we) ? aligned : '0;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words; power of two, 16..65536.
REQ-002 SHALL have parameter LATENCY, default 1: request-to-response cycles, 1..4.
REQ-003 SHALL have parameter INIT_FILE, default "": hex image loaded at elaboration; empty means contents are unspecified.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present this cycle.
REQ-007 req_ready  out  1  block accepts a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (bits [7:0] for SB).
REQ-011 req_size  in  2  mem_size_t: BYTE=0, HALF=1, WORD=2; 3 is illegal.
REQ-012 req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for stores and WORD.
REQ-013 rsp_valid  out  1  response for the oldest accepted request.
REQ-014 rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  out  1  request was misaligned, out of range or illegal size.

Function
REQ-016 A request SHALL be accepted when req_valid and req_ready are both 1; req_ready SHALL be 1 in every cycle except while rst is 1.
REQ-017 Each accepted request SHALL produce exactly one response with rsp_valid=1, LATENCY cycles after acceptance, in acceptance order; the response side has no backpressure.
REQ-018 Back-to-back acceptance SHALL be supported: one request per cycle sustained, with no bubbles.
REQ-019 Word index SHALL be req_addr[31:2]; the request is out of range when that index is >= DEPTH_WORDS.
REQ-020 Misalignment rules: HALF with addr[0]=1 is misaligned; WORD with addr[1:0]!=0 is misaligned.
REQ-021 An erroneous request SHALL modify no memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-022 Store byte lanes: BYTE writes lane addr[1:0] only; HALF writes lanes {addr[1],0} and {addr[1],1}; WORD writes all four lanes. Unselected lanes SHALL keep their contents.
REQ-023 A store SHALL update the array at the clock edge on which it is accepted.
REQ-024 A load accepted in any later cycle SHALL observe that store, including a load issued back-to-back in the next cycle.
REQ-025 Loads SHALL sample the array at the acceptance edge and carry the sampled word through LATENCY-1 pipeline registers.
REQ-026 Load result SHALL be the selected byte or halfword shifted to bit 0, then sign- or zero-extended per req_unsigned.
REQ-027 Store responses SHALL have rsp_valid=1, rsp_err=0 and rsp_rdata=0.
REQ-028 Address bits [31:2+log2(DEPTH_WORDS)] SHALL only affect the range check.

Reset
REQ-029 While rst=1: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and all pipeline valid bits are cleared.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight responses; no response for those requests appears after rst deasserts.
REQ-031 Reset SHALL NOT alter the memory array; stores already committed remain.
REQ-032 The first request SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-033 mem_size_t SHALL be placed in the shared riscv_structures package.
REQ-034 A shared constant XLEN=32 SHALL also be placed in that package.
REQ-035 Load extraction and extension SHALL be one combinational sub-module, load_align: inputs word, offset, size and unsigned; output 32-bit result.
REQ-036 The array SHALL be a single 32-bit-wide memory with per-lane write enables, inferable as block RAM with byte enables.

Verification
REQ-037 SW 0xDEADBEEF @0x0, then LW @0x0 with LATENCY=1 -> rsp_valid 1 cycle after each request; load data = 0xDEADBEEF.
REQ-038 SB 0x80 @0x3 over 0x12345678; then LB @0x3 -> 0xFFFFFF80, LBU @0x3 -> 0x00000080, LW @0x0 -> 0x80345678.
REQ-039 SH 0xBEEF @0x6; then LH @0x6 -> 0xFFFFBEEF, LHU @0x6 -> 0x0000BEEF. LH @0x5 -> rsp_err=1, rdata=0.
REQ-040 SW 0x11111111 @0x1 (misaligned) and SW @DEPTH_WORDS*4 (out of range) -> rsp_err=1 for both; a following LW @0x0 returns unchanged contents.
REQ-041 LATENCY=3, 8 back-to-back alternating SW/LW to @0x40..0x5C -> 8 in-order responses at cycles t+3..t+10; each load returns the value of the store issued just before it.
REQ-042 rst asserted 1 cycle after 2 LWs accepted (LATENCY=3) -> no rsp_valid during or after reset for those requests; a post-reset LW still returns pre-reset store data.
